// File: rtl/sad_best_select.sv
// Accumulates ROWS rows of five candidate SADs per block, then scans the block
// totals one per cycle and presents the minimum-cost candidate on a valid/ready port.
module sad_best_select #(
  parameter int ROWS  = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sad_valid,
  input  logic [59:0]      sad,
  output logic             in_ready,
  input  logic             blk_abort,
  output logic             best_valid,
  output logic [2:0]       best_idx,
  output logic [ACC_W-1:0] best_sad,
  input  logic             out_ready
);

  typedef enum logic [1:0] {ACC, SEL, OUT} state_t;

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc [5];
  logic [CNT_W-1:0] row_cnt;
  logic [2:0]       scan;
  logic [2:0]       cand;
  logic [ACC_W-1:0] cand_sad;
  logic             accept, last_row, handshake;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [11:0]      b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  // Both handshake-ready outputs decode the state register only, so no input
  // reaches an output combinationally.
  assign in_ready   = (state == ACC);
  assign best_valid = (state == OUT);
  assign accept     = sad_valid && in_ready;
  assign handshake  = best_valid && out_ready;
  assign last_row   = (row_cnt == CNT_W'(ROWS - 1));

  // Scan order 2,1,3,0,4 puts full-pel first so it wins every tie.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cand = 3'd2;
    case (scan)
      3'd0:    cand = 3'd2;
      3'd1:    cand = 3'd1;
      3'd2:    cand = 3'd3;
      3'd3:    cand = 3'd0;
      3'd4:    cand = 3'd4;
      default: cand = 3'd2;
    endcase
    cand_sad = acc[cand];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (!blk_abort && accept && last_row) state_nxt = SEL;
      SEL:     if (blk_abort)                        state_nxt = ACC;
               else if (scan == 3'd4)                state_nxt = OUT;
      OUT:     if (handshake)                        state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      row_cnt  <= '0;
      scan     <= '0;
      best_idx <= '0;
      best_sad <= '0;
      // NOTE: the five accumulators are plain flops, not a RAM, so resetting them is cheap and required.
      for (int k = 0; k < 5; k++) acc[k] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ACC: begin
          if (blk_abort) begin
            row_cnt <= '0;
            scan    <= '0;
            for (int k = 0; k < 5; k++) acc[k] <= '0;
          end else if (accept) begin
            for (int k = 0; k < 5; k++) acc[k] <= sat_add(acc[k], sad[12*k +: 12]);
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            scan    <= '0;
          end
        end
        SEL: begin
          if (blk_abort) begin
            row_cnt <= '0;
            scan    <= '0;
            for (int k = 0; k < 5; k++) acc[k] <= '0;
          end else begin
            if (scan == 3'd0 || cand_sad < best_sad) begin
              best_sad <= cand_sad;
              best_idx <= cand;
            end
            scan <= scan + 3'd1;
          end
        end
        OUT: begin
          if (handshake) for (int k = 0; k < 5; k++) acc[k] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sad_best_select.md
# sad_best_select

Downstream of the per-row SAD stage. Each cycle this block can accept one row's packed vector of five 12-bit horizontal-candidate SADs. It accumulates ROWS rows per block, then scans the five block totals sequentially and reports the minimum-cost sub-pixel position with a valid/ready handshake. The winning index and cost feed the motion-vector refinement logic.

## Interface
- ROWS, default 8: rows accumulated per block; legal range 2..16.
- ACC_W, default 16: accumulator width per candidate; must satisfy 12 + ceil(log2(ROWS)) ≤ ACC_W.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sad_valid  in  1  the `sad` vector is valid this cycle.
- sad  in  60  packed row SADs: [11:0] right quarter (idx 0), [23:12] right half (1), [35:24] full (2), [47:36] left half (3), [59:48] left quarter (4).
- in_ready  out  1  block can accept a row; high only in state ACC.
- blk_abort  in  1  synchronous discard of the current block.
- best_valid  out  1  result available; high only in state OUT.
- best_idx  out  3  winning candidate index, 0..4.
- best_sad  out  ACC_W  accumulated SAD of the winner.
- out_ready  in  1  consumer accepts the result.

## Operation
- FSM has three states: ACC, SEL, OUT. Reset state is ACC.
- Reset values: acc[0..4]=0, row_cnt=0, scan=0, in_ready=1, best_valid=0, best_idx=0, best_sad=0.
- ACC
  - Row accept condition: sad_valid && in_ready.
  - On accept: acc[k] <= acc[k] + sad[12k+11:12k] for all five k, and row_cnt++.
  - When the accepted row is row ROWS-1: row_cnt <= 0 and the state goes to SEL with scan=0.
- Accumulators are unsigned and saturate at 2^ACC_W-1; they never wrap.
- SEL
  - One candidate is compared per cycle, in fixed scan order 2, 1, 3, 0, 4 (full, right half, left half, right quarter, left quarter).
  - Scan step 0 loads the running best unconditionally: best_sad <= acc[2], best_idx <= 2.
  - Each later step replaces the running best only if acc[cand] < best_sad (strict). Ties therefore resolve in scan order, so full-pel wins all ties.
  - After step 4 the state goes to OUT.
  - in_ready=0 throughout SEL; rows presented during SEL are not accepted.
- OUT
  - best_valid=1. best_idx and best_sad hold stable until the handshake.
  - Handshake is best_valid && out_ready. On handshake: acc[*] <= 0 and the state goes to ACC. best_idx and best_sad keep their last values.
- blk_abort
  - In ACC or SEL: clears acc[*], row_cnt and scan; state goes to ACC. No result is produced.
  - In OUT: ignored; the result still completes.
  - blk_abort takes priority over a simultaneous row accept; that row is discarded.
- Asynchronous reset mid-block: every register returns to its reset value immediately and no partial result is emitted.

## Timing
- Row throughput: one row per cycle in ACC, with no bubbles between rows.
- Latency: let the last row be accepted at edge E0.
  - SEL occupies the cycles following E0 through E5 (5 edges).
  - best_valid is high from just after E5.
  - Minimum block period is ROWS + 5 cycles plus 1 handshake cycle. With out_ready tied high, that is ROWS + 6 cycles per block.
- in_ready rises the cycle after the OUT handshake. Back-to-back blocks need no extra idle cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Basic block, ROWS=8: every row has sad fields {idx4..idx0} = {40, 30, 10, 20, 50}.
  - Required: best_idx=2, best_sad=80, best_valid 5 cycles after the 8th accept.
- Tie-break: every row has all five fields = 7.
  - Required: best_idx=2, best_sad=56. Then repeat with full=9 and the other four fields=7; required: best_idx=1, best_sad=56.
- Back-pressure: hold out_ready=0 for 10 cycles in OUT while sad_valid=1.
  - Required: in_ready=0, best_idx/best_sad stable, no row accepted.
  - Then raise out_ready; the next block's first row is accepted the following cycle.
- Abort mid-block: blk_abort after row 3. The next full block uses right quarter=1 and all other fields=100 per row.
  - Required: best_idx=0, best_sad=8, with no residue from the aborted rows.
- Saturation: ACC_W=13 and every field=4095 for 8 rows.
  - Required: best_sad=8191 (saturated), best_idx=2.
- Asynchronous reset: assert rst_n=0 mid-SEL.
  - Required: best_valid=0 and in_ready=1 immediately. The next block result matches a fresh run.
